// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and WB: performs LOAD/STORE on a req/gnt/rvalid
// data bus, aligns and extends load data, and passes all other instructions straight through.
module mem_stage #(
   parameter int BITSIZE = 32
) (
   input  logic               clk,
   input  logic               resetn_i,
   input  logic               EX_MEM_give_i,
   output logic               MEM_EX_get_o,
   input  logic [31:0]        EX_MEM_instruction_i,
   input  logic [BITSIZE-1:0] EX_MEM_pc_i,
   input  logic [BITSIZE-1:0] EX_MEM_result_i,
   input  logic [BITSIZE-1:0] EX_MEM_rs2_i,
   output logic               data_req_o,
   output logic               data_we_o,
   output logic [3:0]         data_be_o,
   output logic [BITSIZE-1:0] data_addr_o,
   output logic [BITSIZE-1:0] data_wdata_o,
   input  logic               data_gnt_i,
   input  logic               data_rvalid_i,
   input  logic [BITSIZE-1:0] data_rdata_i,
   output logic               MEM_WB_give_o,
   input  logic               WB_MEM_get_i,
   output logic [31:0]        MEM_WB_instruction_o,
   output logic [BITSIZE-1:0] MEM_WB_pc_o,
   output logic [BITSIZE-1:0] MEM_WB_result_o,
   output logic               misaligned_o
);

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

   state_t               state_q, state_d;
   logic                 get_q, get_d;
   logic                 give_q, give_d;
   logic                 req_q, req_d;
   logic                 we_q, we_d;
   logic [3:0]           be_q, be_d;
   logic [BITSIZE-1:0]   addr_q, addr_d;
   logic [BITSIZE-1:0]   wdata_q, wdata_d;
   logic [31:0]          instr_q, instr_d;
   logic [BITSIZE-1:0]   pc_q, pc_d;
   logic [BITSIZE-1:0]   result_q, result_d;
   logic                 misaligned_q, misaligned_d;

   logic                 in_load, in_store, in_supported, in_aligned;
   logic [2:0]           in_f3;
   logic [1:0]           in_off;

   function automatic logic f3_supported(input logic is_load, input logic [2:0] f3);
      if (is_load) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                          (f3 == 3'b100) || (f3 == 3'b101);
      else         return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
   endfunction

   // Size lives in funct3[1:0] for both loads and stores.
   function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return 1'b1;
         2'b01:   return ~off[0];
         default: return off == 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return 4'b0001 << off;
         2'b01:   return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [BITSIZE-1:0] store_data(input logic [2:0] f3,
                                                     input logic [BITSIZE-1:0] rs2);
      case (f3[1:0])
         2'b00:   return {4{rs2[7:0]}};
         2'b01:   return {2{rs2[15:0]}};
         default: return rs2;
      endcase
   endfunction

   function automatic logic [BITSIZE-1:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [BITSIZE-1:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'b00:   b = rdata[7:0];
         2'b01:   b = rdata[15:8];
         2'b10:   b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'b0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'b0, h};
         default: return rdata;
      endcase
   endfunction

   assign in_f3        = EX_MEM_instruction_i[14:12];
   assign in_off       = EX_MEM_result_i[1:0];
   assign in_load      = EX_MEM_instruction_i[6:0] == OPC_LOAD;
   assign in_store     = EX_MEM_instruction_i[6:0] == OPC_STORE;
   assign in_supported = (in_load || in_store) && f3_supported(in_load, in_f3);
   assign in_aligned   = is_aligned(in_f3, in_off);

   always_comb begin
      state_d      = state_q;
      get_d        = get_q;
      give_d       = give_q;
      req_d        = req_q;
      we_d         = we_q;
      be_d         = be_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      instr_d      = instr_q;
      pc_d         = pc_q;
      result_d     = result_q;
      misaligned_d = 1'b0;

      case (state_q)
         IDLE: begin
            get_d = 1'b1;
            if (get_q && EX_MEM_give_i) begin
               get_d    = 1'b0;
               instr_d  = EX_MEM_instruction_i;
               pc_d     = EX_MEM_pc_i;
               result_d = EX_MEM_result_i;
               if (in_supported && in_aligned) begin
                  state_d = REQ;
                  req_d   = 1'b1;
                  we_d    = in_store;
                  be_d    = byte_en(in_f3, in_off);
                  addr_d  = {EX_MEM_result_i[BITSIZE-1:2], 2'b00};
                  wdata_d = in_store ? store_data(in_f3, EX_MEM_rs2_i) : '0;
               end else if (in_supported) begin
                  state_d      = DONE;
                  give_d       = 1'b1;
                  result_d     = '0;
                  misaligned_d = 1'b1;
               end else begin
                  state_d = DONE;
                  give_d  = 1'b1;
               end
            end
         end
         REQ: begin
            if (data_gnt_i) begin
               req_d = 1'b0;
               if (we_q) begin
                  state_d = DONE;
                  give_d  = 1'b1;
               end else begin
                  state_d = WAIT_R;
               end
            end
         end
         WAIT_R: begin
            // result_q still holds the effective address, so its low bits select the lane.
            if (data_rvalid_i) begin
               result_d = load_align(instr_q[14:12], result_q[1:0], data_rdata_i);
               state_d  = DONE;
               give_d   = 1'b1;
            end
         end
         default: begin
            if (WB_MEM_get_i) begin
               state_d = IDLE;
               give_d  = 1'b0;
               get_d   = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q      <= IDLE;
         get_q        <= 1'b0;
         give_q       <= 1'b0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         be_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         instr_q      <= '0;
         pc_q         <= '0;
         result_q     <= '0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         get_q        <= get_d;
         give_q       <= give_d;
         req_q        <= req_d;
         we_q         <= we_d;
         be_q         <= be_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         result_q     <= result_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign MEM_EX_get_o         = get_q;
   assign data_req_o           = req_q;
   assign data_we_o            = we_q;
   assign data_be_o            = be_q;
   assign data_addr_o          = addr_q;
   assign data_wdata_o         = wdata_q;
   assign MEM_WB_give_o        = give_q;
   assign MEM_WB_instruction_o = instr_q;
   assign MEM_WB_pc_o          = pc_q;
   assign MEM_WB_result_o      = result_q;
   assign misaligned_o         = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized instructions checked against
// an arithmetic model of load/store lane selection, extension and handshake timing.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        resetn_i;
   logic        EX_MEM_give_i;
   logic        MEM_EX_get_o;
   logic [31:0] EX_MEM_instruction_i;
   logic [31:0] EX_MEM_pc_i;
   logic [31:0] EX_MEM_result_i;
   logic [31:0] EX_MEM_rs2_i;
   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;
   logic        MEM_WB_give_o;
   logic        WB_MEM_get_i;
   logic [31:0] MEM_WB_instruction_o;
   logic [31:0] MEM_WB_pc_o;
   logic [31:0] MEM_WB_result_o;
   logic        misaligned_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_stage #(.BITSIZE(32)) dut (
      .clk                 (clk),
      .resetn_i            (resetn_i),
      .EX_MEM_give_i       (EX_MEM_give_i),
      .MEM_EX_get_o        (MEM_EX_get_o),
      .EX_MEM_instruction_i(EX_MEM_instruction_i),
      .EX_MEM_pc_i         (EX_MEM_pc_i),
      .EX_MEM_result_i     (EX_MEM_result_i),
      .EX_MEM_rs2_i        (EX_MEM_rs2_i),
      .data_req_o          (data_req_o),
      .data_we_o           (data_we_o),
      .data_be_o           (data_be_o),
      .data_addr_o         (data_addr_o),
      .data_wdata_o        (data_wdata_o),
      .data_gnt_i          (data_gnt_i),
      .data_rvalid_i       (data_rvalid_i),
      .data_rdata_i        (data_rdata_i),
      .MEM_WB_give_o       (MEM_WB_give_o),
      .WB_MEM_get_i        (WB_MEM_get_i),
      .MEM_WB_instruction_o(MEM_WB_instruction_o),
      .MEM_WB_pc_o         (MEM_WB_pc_o),
      .MEM_WB_result_o     (MEM_WB_result_o),
      .misaligned_o        (misaligned_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: access size in bytes from funct3.
   function automatic int unsigned acc_size(input logic [2:0] f3);
      return 32'd1 << f3[1:0];
   endfunction

   function automatic bit model_supported(input bit is_load, input logic [2:0] f3);
      if (is_load) return (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      return f3 <= 2;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      logic [31:0] lane;
      logic [31:0] v;
      int unsigned sz;
      sz   = acc_size(f3);
      lane = rdata >> (8 * addr[1:0]);
      if (sz == 1) begin
         v = lane & 32'hFF;
         if (!f3[2] && v >= 128) v = v - 32'd256;
      end else if (sz == 2) begin
         v = lane & 32'hFFFF;
         if (!f3[2] && v >= 32768) v = v - 32'd65536;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   task automatic wait_get(input string tag);
      int n = 0;
      while (MEM_EX_get_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " get_ready"}, 32'(MEM_EX_get_o), 32'd1);
   endtask

   task automatic run_txn(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                          input int wb_dly);
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] exp_res;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_be;
      bit          is_load, is_store, mem, aligned, exp_mis;
      int unsigned sz;
      int          reqcnt;

      instr       = $urandom;
      instr[14:12] = f3;
      instr[6:0]  = opc;
      pc          = $urandom;
      is_load     = (opc == 7'b0000011);
      is_store    = (opc == 7'b0100011);
      mem         = (is_load || is_store) && model_supported(is_load, f3);
      sz          = acc_size(f3);
      aligned     = (addr % sz) == 0;
      exp_be      = 4'(((32'd1 << sz) - 1) << addr[1:0]);
      exp_wdata   = (sz == 1) ? (rs2 & 32'hFF) * 32'h0101_0101 :
                    (sz == 2) ? (rs2 & 32'hFFFF) * 32'h0001_0001 : rs2;
      exp_mis     = 1'b0;
      exp_res     = addr;

      wait_get(tag);
      EX_MEM_give_i        = 1'b1;
      EX_MEM_instruction_i = instr;
      EX_MEM_pc_i          = pc;
      EX_MEM_result_i      = addr;
      EX_MEM_rs2_i         = rs2;
      @(negedge clk);
      EX_MEM_give_i        = 1'b0;
      EX_MEM_instruction_i = $urandom;
      EX_MEM_pc_i          = $urandom;
      EX_MEM_result_i      = $urandom;
      EX_MEM_rs2_i         = $urandom;
      check({tag, " get_busy"}, 32'(MEM_EX_get_o), 32'd0);

      if (mem && aligned) begin
         reqcnt = 0;
         check({tag, " we"}, 32'(data_we_o), 32'(is_store));
         check({tag, " give_early"}, 32'(MEM_WB_give_o), 32'd0);
         if (is_store) check({tag, " wdata"}, data_wdata_o, exp_wdata);
         for (int k = 0; k <= gnt_dly; k++) begin
            if (k > 0) @(negedge clk);
            if (data_req_o === 1'b1) reqcnt++;
            check({tag, " addr"}, data_addr_o, addr & 32'hFFFF_FFFC);
            check({tag, " be"}, 32'(data_be_o), 32'(exp_be));
         end
         data_gnt_i = 1'b1;
         @(negedge clk);
         data_gnt_i = 1'b0;
         check({tag, " req_cycles"}, reqcnt, gnt_dly + 1);
         check({tag, " req_drop"}, 32'(data_req_o), 32'd0);
         if (is_load) begin
            for (int k = 0; k < rv_dly; k++) begin
               check({tag, " give_wait"}, 32'(MEM_WB_give_o), 32'd0);
               @(negedge clk);
            end
            check({tag, " give_wait"}, 32'(MEM_WB_give_o), 32'd0);
            data_rvalid_i = 1'b1;
            data_rdata_i  = rdata;
            @(negedge clk);
            data_rvalid_i = 1'b0;
            data_rdata_i  = $urandom;
            exp_res       = model_load(f3, addr, rdata);
         end
      end else if (mem) begin
         exp_res = 32'd0;
         exp_mis = 1'b1;
         check({tag, " no_req"}, 32'(data_req_o), 32'd0);
      end else begin
         check({tag, " no_req"}, 32'(data_req_o), 32'd0);
      end

      check({tag, " give"}, 32'(MEM_WB_give_o), 32'd1);
      check({tag, " result"}, MEM_WB_result_o, exp_res);
      check({tag, " instr"}, MEM_WB_instruction_o, instr);
      check({tag, " pc"}, MEM_WB_pc_o, pc);
      check({tag, " misaligned"}, 32'(misaligned_o), 32'(exp_mis));
      for (int k = 0; k < wb_dly; k++) begin
         @(negedge clk);
         check({tag, " stall_give"}, 32'(MEM_WB_give_o), 32'd1);
         check({tag, " stall_result"}, MEM_WB_result_o, exp_res);
         check({tag, " stall_instr"}, MEM_WB_instruction_o, instr);
         check({tag, " stall_get"}, 32'(MEM_EX_get_o), 32'd0);
         check({tag, " stall_mis"}, 32'(misaligned_o), 32'd0);
      end
      WB_MEM_get_i = 1'b1;
      @(negedge clk);
      WB_MEM_get_i = 1'b0;
      check({tag, " give_clr"}, 32'(MEM_WB_give_o), 32'd0);
      check({tag, " back_idle"}, 32'(MEM_EX_get_o), 32'd1);
      check({tag, " mis_clr"}, 32'(misaligned_o), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " get"}, 32'(MEM_EX_get_o), 32'd0);
      check({tag, " req"}, 32'(data_req_o), 32'd0);
      check({tag, " we"}, 32'(data_we_o), 32'd0);
      check({tag, " be"}, 32'(data_be_o), 32'd0);
      check({tag, " addr"}, data_addr_o, 32'd0);
      check({tag, " wdata"}, data_wdata_o, 32'd0);
      check({tag, " give"}, 32'(MEM_WB_give_o), 32'd0);
      check({tag, " instr"}, MEM_WB_instruction_o, 32'd0);
      check({tag, " pc"}, MEM_WB_pc_o, 32'd0);
      check({tag, " result"}, MEM_WB_result_o, 32'd0);
      check({tag, " mis"}, 32'(misaligned_o), 32'd0);
   endtask

   initial begin
      logic [6:0]  opc;
      logic [31:0] instr;
      resetn_i             = 1'b0;
      EX_MEM_give_i        = 1'b0;
      EX_MEM_instruction_i = '0;
      EX_MEM_pc_i          = '0;
      EX_MEM_result_i      = '0;
      EX_MEM_rs2_i         = '0;
      data_gnt_i           = 1'b0;
      data_rvalid_i        = 1'b0;
      data_rdata_i         = '0;
      WB_MEM_get_i         = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      resetn_i = 1'b1;

      run_txn("add_pass", 7'b0110011, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0);
      run_txn("lb",       7'b0000011, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 1, 0);
      run_txn("lbu",      7'b0000011, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1, 0, 0);
      run_txn("sh",       7'b0100011, 3'b001, 32'h0000_0102, 32'hABCD_1234, 32'h0, 3, 0, 0);
      run_txn("sb",       7'b0100011, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0, 0, 0, 0);
      run_txn("lh_hi",    7'b0000011, 3'b001, 32'h0000_0402, 32'h0, 32'h8001_7FFF, 0, 2, 0);
      run_txn("lw_mis",   7'b0000011, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 0, 0);
      run_txn("sh_mis",   7'b0100011, 3'b001, 32'h0000_0103, 32'h1, 32'h0, 0, 0, 1);
      run_txn("ld_unsup", 7'b0000011, 3'b111, 32'h0000_0555, 32'h0, 32'h0, 0, 0, 0);
      run_txn("wb_stall", 7'b0000011, 3'b010, 32'h0000_0800, 32'h0, 32'hDEAD_BEEF, 0, 0, 5);

      // Abort a load in WAIT_R with an asynchronous reset, then offer a stray rvalid.
      wait_get("rst_ld");
      instr                = 32'h0000_2003;
      EX_MEM_give_i        = 1'b1;
      EX_MEM_instruction_i = instr;
      EX_MEM_pc_i          = 32'h0000_0040;
      EX_MEM_result_i      = 32'h0000_0200;
      @(negedge clk);
      EX_MEM_give_i = 1'b0;
      data_gnt_i    = 1'b1;
      @(negedge clk);
      data_gnt_i = 1'b0;
      check("rst_ld in_wait", 32'(data_req_o), 32'd0);
      #2 resetn_i = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      resetn_i      = 1'b1;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h1234_5678;
      @(negedge clk);
      data_rvalid_i = 1'b0;
      check("stray_rv give", 32'(MEM_WB_give_o), 32'd0);
      check("stray_rv result", MEM_WB_result_o, 32'd0);
      run_txn("post_rst", 7'b0000011, 3'b101, 32'h0000_0302, 32'h0, 32'hF00D_0000, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       opc = 7'b0000011;
            1:       opc = 7'b0100011;
            2:       opc = 7'b0110011;
            default: opc = 7'b0010011;
         endcase
         run_txn($sformatf("rnd%0d", i), opc, 3'($urandom_range(0, 7)), $urandom, $urandom,
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
